// File: rtl/compare_arbiter.sv
// Purpose: round-robin share of one 64-bit subtract/compare datapath between two requesters.
// Latency: handshake at T, compare at T+1, response valid from T+2 until accepted (II = 3).
// Backpressure: one op in flight, no request accepted in CALC/RESP, RESP held until owner rsp_ready.
// Build option: CMP_UNSIGNED_EN enables the LTU op; without it LTU answers 0 with rsp_illegal set.
module compare_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic        rsp_result,
  output logic        rsp_illegal,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic [63:0] a_q, b_q;
  logic [1:0]  op_q;
  logic        result_q, illegal_q;
  logic        gnt0, gnt1, hs;
  logic [63:0] s;
  logic        eq, lt;
  logic        res_d, ill_d;

  // Round-robin grant: a lone requester wins, contention goes to the port not served last
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | last_grant_q);
    gnt1 = req1_valid & (~req0_valid | ~last_grant_q);
  end

  // Ready only in IDLE; gated by rst_n so every output reads 0 while reset is held
  assign req0_ready = rst_n & (state_q == IDLE) & gnt0;
  assign req1_ready = rst_n & (state_q == IDLE) & gnt1;
  assign hs         = (req0_valid & req0_ready) | (req1_valid & req1_ready);

`ifdef CMP_UNSIGNED_EN
  logic c_o;
  assign {c_o, s} = {1'b0, a_q} + {1'b0, ~b_q} + 65'd1;
`else
  assign s = a_q + ~b_q + 64'd1;
`endif

  // Compare flags from the shared subtractor; signs that differ decide LT without overflow concerns
  always_comb begin
    eq = (s == 64'd0);
    lt = (a_q[63] != b_q[63]) ? a_q[63] : s[63];
  end

  // Select the outcome for the latched op
  always_comb begin
    res_d = 1'b0;
    ill_d = 1'b0;
    case (op_q)
      2'b00: res_d = eq;
      2'b01: res_d = lt;
      2'b10: begin
`ifdef CMP_UNSIGNED_EN
        res_d = ~c_o;
`else
        ill_d = 1'b1;
`endif
      end
      default: res_d = ~lt;
    endcase
  end

  // Next-state: accept in IDLE, one compare cycle, hold response until the owner takes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand/owner capture at handshake, result capture in CALC; last_grant=1 lets port 0 win first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= 64'd0;
      b_q          <= 64'd0;
      op_q         <= 2'b00;
      result_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      if (hs) begin
        owner_q      <= gnt1;
        last_grant_q <= gnt1;
        a_q          <= gnt1 ? req1_a  : req0_a;
        b_q          <= gnt1 ? req1_b  : req0_b;
        op_q         <= gnt1 ? req1_op : req0_op;
      end
      if (state_q == CALC) begin
        result_q  <= res_d;
        illegal_q <= ill_d;
      end
    end
  end

  assign rsp0_valid  = (state_q == RESP) & ~owner_q;
  assign rsp1_valid  = (state_q == RESP) &  owner_q;
  assign rsp_result  = result_q;
  assign rsp_illegal = illegal_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_compare_arbiter.sv
// Bench for compare_arbiter: directed steps plus random traffic against a behavioural model.
// Expected responses are queued at each request handshake and matched when a response appears.
// Honours CMP_UNSIGNED_EN the same way the design does when computing LTU expectations.
module tb_compare_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic        rsp_result, rsp_illegal, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cnt = 0;
  int last_hs = -1;
  logic alt_chk = 1'b0;
  logic alt_port = 1'b0;

  typedef struct packed {logic port; logic res; logic ill;} exp_t;
  exp_t exp_q[$];

  compare_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference semantics straight from the op definitions
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                                output logic r, output logic ill);
    r = 1'b0;
    ill = 1'b0;
    case (op)
      2'b00: r = (a == b);
      2'b01: r = ($signed(a) < $signed(b));
      2'b10: begin
`ifdef CMP_UNSIGNED_EN
        r = (a < b);
`else
        r = 1'b0;
        ill = 1'b1;
`endif
      end
      default: r = !($signed(a) < $signed(b));
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic note_hs(input logic p);
    if (alt_chk) begin
      check("grant_alternates", p, alt_port);
      if (last_hs >= 0) check("hs_interval", cyc - last_hs, 3);
      alt_port = ~alt_port;
    end
    last_hs = cyc;
    hs_cnt++;
  endtask

  // Sample mid-low-phase: log handshakes into the scoreboard and match any response
  task automatic sample();
    logic r, il;
    #1;
    if (req0_valid && req0_ready) begin
      model(req0_a, req0_b, req0_op, r, il);
      exp_q.push_back('{1'b0, r, il});
      note_hs(1'b0);
    end
    if (req1_valid && req1_ready) begin
      model(req1_a, req1_b, req1_op, r, il);
      exp_q.push_back('{1'b1, r, il});
      note_hs(1'b1);
    end
    check("ready_exclusive", req0_ready && req1_ready, 0);
    if (rsp0_valid || rsp1_valid) begin
      check("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("rsp_port", {rsp1_valid, rsp0_valid}, exp_q[0].port ? 2'b10 : 2'b01);
        check("rsp_result", rsp_result, exp_q[0].res);
        check("rsp_illegal", rsp_illegal, exp_q[0].ill);
        if (exp_q[0].port ? rsp1_ready : rsp0_ready) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_ops();
    req0_a = {$urandom, $urandom};
    req0_b = ($urandom_range(0, 3) == 0) ? req0_a : {$urandom, $urandom};
    req0_op = 2'($urandom_range(0, 3));
    req1_a = {$urandom, $urandom};
    req1_b = ($urandom_range(0, 3) == 0) ? req1_a : {$urandom, $urandom};
    req1_op = 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    adv();
    rst_n = 1'b1;
    adv();
  endtask

  // One full transaction on port p with explicit per-phase checks
  task automatic single(input logic p, input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    logic r, il;
    model(a, b, op, r, il);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (p) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    sample();
    check("hs_ready", p ? req1_ready : req0_ready, 1);
    adv();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rand_ops();
    sample();
    check("calc_busy", busy, 1);
    check("calc_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    adv();
    sample();
    check("resp_valid", {rsp1_valid, rsp0_valid}, p ? 2'b10 : 2'b01);
    check("resp_result", rsp_result, r);
    check("resp_illegal", rsp_illegal, il);
    adv();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    sample();
    check("back_to_idle", busy, 0);
    adv();
  endtask

  initial begin
    // Reset state, with a request already pending
    adv();
    req0_valid = 1'b1;
    sample();
    check("rst_req0_ready", req0_ready, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    check("rst_result", rsp_result, 0);
    check("rst_illegal", rsp_illegal, 0);
    check("rst_busy", busy, 0);
    adv();
    req0_valid = 1'b0;
    rst_n = 1'b1;
    adv();

    // Directed compares
    single(1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 2'b01);
    single(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00);
    single(1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 2'b01);
    single(1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 2'b11);
    single(1'b1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10);
    single(1'b0, 64'd7, 64'd7, 2'b11);
    single(1'b0, 64'd2, 64'd9, 2'b00);

    // Response stall on port 1 while port 0 waits
    req1_valid = 1'b1; req1_a = 64'd5; req1_b = 64'd9; req1_op = 2'b01;
    sample();
    adv();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 64'd4; req0_b = 64'd4; req0_op = 2'b00;
    sample();
    check("calc_req0_blocked", req0_ready, 0);
    adv();
    repeat (10) begin
      sample();
      check("stall_rsp1_valid", rsp1_valid, 1);
      check("stall_result", rsp_result, 1);
      check("stall_req0_ready", req0_ready, 0);
      check("stall_busy", busy, 1);
      adv();
    end
    rsp1_ready = 1'b1;
    sample();
    adv();
    rsp1_ready = 1'b0;
    sample();
    check("release_busy", busy, 0);
    check("release_req0_ready", req0_ready, 1);
    adv();
    req0_valid = 1'b0;
    sample();
    adv();
    rsp0_ready = 1'b1;
    sample();
    adv();
    rsp0_ready = 1'b0;
    check("stall_drained", exp_q.size(), 0);

    // Continuous contention after reset: grants alternate starting with port 0
    do_reset();
    alt_chk = 1'b1;
    alt_port = 1'b0;
    last_hs = -1;
    hs_cnt = 0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (13) begin
      rand_ops();
      sample();
      adv();
    end
    alt_chk = 1'b0;
    check("contention_hs_count", hs_cnt, 5);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) begin sample(); adv(); end
    check("contention_drained", exp_q.size(), 0);

    // Random traffic with random backpressure
    repeat (400) begin
      rand_ops();
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      rsp0_ready = ($urandom_range(0, 1) != 0);
      rsp1_ready = ($urandom_range(0, 1) != 0);
      sample();
      adv();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (4) begin sample(); adv(); end
    check("random_drained", exp_q.size(), 0);

    // Reset pulse during CALC discards the in-flight op
    req1_valid = 1'b1; req1_a = 64'd3; req1_b = 64'd3; req1_op = 2'b00;
    sample();
    adv();
    req1_valid = 1'b0;
    rst_n = 1'b0;
    sample();
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    check("midrst_result", rsp_result, 0);
    check("midrst_illegal", rsp_illegal, 0);
    check("midrst_ready", {req1_ready, req0_ready}, 2'b00);
    exp_q.delete();
    adv();
    adv();
    rst_n = 1'b1;
    repeat (4) begin
      sample();
      check("postrst_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      adv();
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rand_ops();
    sample();
    check("postrst_grant", {req1_ready, req0_ready}, 2'b01);
    adv();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) begin sample(); adv(); end
    check("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/compare_arbiter.md
# compare_arbiter

Shares one 64-bit subtract-and-compare datapath (adder64b in subtract mode, comparator_eq, comparator_lt_signed) between two requesters: port 0 (branch unit) and port 1 (integer ALU SLT/SLTU and FP-compare integer path). It arbitrates round-robin, latches the operands, computes the compare in a dedicated cycle and holds a registered result until the owning requester accepts it. It sits between the execute-stage issue logic and the shared compare hardware.

## Interface
- No parameters; data width fixed at 64.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  64  operands (two's complement for signed ops)
- req0_op / req1_op  in  2  00 EQ, 01 LT signed, 10 LTU, 11 GE signed
- rsp0_valid / rsp1_valid  out  1  result available for that port
- rsp0_ready / rsp1_ready  in  1  requester consumes result
- rsp_result  out  1  compare outcome (shared, qualified by rspN_valid)
- rsp_illegal  out  1  op not supported in this build (qualified by rspN_valid)
- busy  out  1  FSM not IDLE

## Operation
- FSM states: IDLE, CALC, RESP. Single outstanding operation.
- IDLE: reqN_ready = 1 only for the granted port; grant is combinational from the valids and last_grant. Only one valid -> that port. Both valid -> port != last_grant. On handshake: latch a, b, op, owner; last_grant <= owner; go CALC.
- CALC: subtractor sees latched operands; s = a - b (64-bit, sub=1), c_o captured. eq = (s == 0). lt = (a[63] != b[63]) ? a[63] : s[63]. ltu = ~c_o. ge = ~lt. Selected result registered into rsp_result; go RESP.
- RESP: rsp<owner>_valid = 1, other rsp valid 0; result and illegal held stable. On rsp<owner>_ready: go IDLE. No reqN_ready asserted in CALC or RESP.
- Reset (any state, any cycle): FSM -> IDLE, last_grant = 1 (port 0 wins first contention), all outputs 0; latched operands discarded, in-flight request lost, no response issued.
- Operands need not be held by requester after handshake.

## Timing
- Handshake cycle T (IDLE, valid&ready) -> CALC at T+1 -> rspN_valid high from T+2.
- Minimum initiation interval 3 cycles (RESP with immediate rsp_ready -> IDLE at T+3, next handshake at T+3).
- rsp_ready low: RESP held indefinitely, outputs stable.
- rsp_ready high before rsp_valid ignored.
- Reset values: reqN_ready 0, rspN_valid 0, rsp_result 0, rsp_illegal 0, busy 0.

## Configuration
- CMP_UNSIGNED_EN defined: op 10 computes ltu = ~c_o; rsp_illegal always 0.
- CMP_UNSIGNED_EN undefined: op 10 accepted and sequenced normally, but rsp_result = 0 and rsp_illegal = 1; ltu logic not built. Ops 00/01/11 identical in both builds.

## Test plan
- Reset then port 0 only: a=-5, b=3, op LT -> req0_ready at handshake, rsp0_valid two cycles later, rsp_result=1, rsp_illegal=0.
- Port 1 EQ: a=b=0x8000_0000_0000_0000 -> rsp_result=1; then a=0x8000_0000_0000_0000, b=0x7FFF_FFFF_FFFF_FFFF, op LT -> 1 (sign differs), op GE -> 0.
- Both valid continuously after reset -> grants alternate 0,1,0,1; each handshake 3 cycles apart with rsp_ready held 1; no port starved.
- rsp1_ready held 0 for 10 cycles in RESP -> rsp1_valid and rsp_result stable, req0_ready stays 0, busy=1; release -> IDLE next cycle.
- op LTU a=1, b=0xFFFF_FFFF_FFFF_FFFF -> with CMP_UNSIGNED_EN result=1, illegal=0; without it result=0, illegal=1.
- rst_n pulsed low during CALC -> all outputs 0 immediately; no rsp_valid afterwards; next contention grants port 0.
